usb_tx_packetizer: RTL and testbench

// TX packet sequencer directly downstream of data_buffer: on a start request it emits

---
 rtl/usb_tx_packetizer.sv | 201 ++++++++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer
// Sequences one USB packet onto the serializer byte interface: SYNC, PID,
// payload bytes popped from the upstream data_buffer, CRC16, then an EOP
// request. Token/handshake packets (tx_has_data=0) go straight from PID to EOP.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   tx_start      start pulse (accepted only while idle)
//   tx_pid        PID nibble; wire byte is {~tx_pid, tx_pid}
//   tx_has_data   1 = DATA packet with payload and CRC16
//   buf_occ       data_buffer occupancy, latched at start and clamped
//   buf_rdata     data_buffer head byte (first-word-fall-through)
//   buf_get       pop strobe, one per transferred payload byte
//   ser_byte      byte to serializer, ser_valid qualifies it
//   ser_ready     serializer accepts a byte or the EOP this cycle
//   ser_eop       EOP request, held until ser_ready
//   tx_busy       packet in progress
//   tx_done       1-cycle pulse when the packet is fully handed off
//   tx_err        1-cycle pulse after a tx_start that arrived while busy
//
// Optional build macro TX_PKT_STATS_EN adds tx_pkt_cnt[15:0] (wrapping count
// of completed packets) and tx_err_cnt[7:0] (saturating count of tx_err).

module usb_tx_packetizer #(
  parameter int         MAX_PKT_BYTES = 64,
  parameter int         OCC_W         = 7,
  parameter logic [7:0] SYNC_BYTE     = 8'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic             tx_has_data,
  input  logic [OCC_W-1:0] buf_occ,
  input  logic [7:0]       buf_rdata,
  output logic             buf_get,
  output logic [7:0]       ser_byte,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_eop,
  output logic             tx_busy,
  output logic             tx_done,
`ifdef TX_PKT_STATS_EN
  output logic [15:0]      tx_pkt_cnt,
  output logic [7:0]       tx_err_cnt,
`endif
  output logic             tx_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP,
    S_DONE
  } state_t;

  localparam logic [OCC_W-1:0] MAX_LEN = OCC_W'(MAX_PKT_BYTES);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       pid_q;
  logic             has_data_q;
  logic [OCC_W-1:0] len_q;
  logic [OCC_W-1:0] cnt_q;
  logic [15:0]      crc_q;
  logic             err_q;
  logic             last_byte;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc,
                                            input logic [7:0]  d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign last_byte = ((cnt_q + OCC_W'(1)) == len_q);
  assign tx_busy   = (state != S_IDLE);
  assign tx_err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ser_valid = 1'b0;
    ser_byte  = 8'h00;
    buf_get   = 1'b0;
    ser_eop   = 1'b0;
    tx_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_start) state_nx = S_SYNC;
      end
      S_SYNC: begin
        ser_valid = 1'b1;
        ser_byte  = SYNC_BYTE;
        if (ser_ready) state_nx = S_PID;
      end
      S_PID: begin
        ser_valid = 1'b1;
        ser_byte  = {~pid_q, pid_q};
        if (ser_ready) begin
          if (!has_data_q)          state_nx = S_EOP;
          else if (len_q == '0)     state_nx = S_CRC_LO;
          else                      state_nx = S_DATA;
        end
      end
      S_DATA: begin
        ser_valid = 1'b1;
        ser_byte  = buf_rdata;
        if (ser_ready) begin
          // A reset arriving mid-payload must not pop a byte it will never send.
          buf_get = !rst;
          if (last_byte) state_nx = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        ser_valid = 1'b1;
        ser_byte  = ~crc_q[7:0];
        if (ser_ready) state_nx = S_CRC_HI;
      end
      S_CRC_HI: begin
        ser_valid = 1'b1;
        ser_byte  = ~crc_q[15:8];
        if (ser_ready) state_nx = S_EOP;
      end
      S_EOP: begin
        ser_eop = 1'b1;
        if (ser_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        tx_done  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Packet context and CRC accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      pid_q      <= 4'h0;
      has_data_q <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= 16'hFFFF;
      err_q      <= 1'b0;
    end else begin
      // A start request is only legal in IDLE; elsewhere (including DONE) it is dropped.
      err_q <= tx_start && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            pid_q      <= tx_pid;
            has_data_q <= tx_has_data;
            len_q      <= (buf_occ > MAX_LEN) ? MAX_LEN : buf_occ;
            cnt_q      <= '0;
            crc_q      <= 16'hFFFF;
          end
        end
        S_DATA: begin
          if (ser_ready) begin
            crc_q <= crc16_upd(crc_q, buf_rdata);
            cnt_q <= cnt_q + OCC_W'(1);
          end
        end
        S_DONE: begin
          crc_q <= 16'hFFFF;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef TX_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pkt_cnt <= 16'h0000;
      tx_err_cnt <= 8'h00;
    end else begin
      if (state == S_DONE) tx_pkt_cnt <= tx_pkt_cnt + 16'h0001;
      if (err_q && (tx_err_cnt != 8'hFF)) tx_err_cnt <= tx_err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Bench for usb_tx_packetizer: an upstream FWFT buffer model, a byte-stream
// monitor and a reference model of the expected wire bytes built from the
// packet format (SYNC, PID, payload, inverted reflected CRC16).
module tb_usb_tx_packetizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_has_data;
  logic [6:0] buf_occ;
  logic [7:0] buf_rdata;
  logic       buf_get;
  logic [7:0] ser_byte;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_eop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
`ifdef TX_PKT_STATS_EN
  logic [15:0] tx_pkt_cnt;
  logic [7:0]  tx_err_cnt;
`endif

  always #5 clk = ~clk;

  usb_tx_packetizer dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_has_data(tx_has_data), .buf_occ(buf_occ), .buf_rdata(buf_rdata),
    .buf_get(buf_get), .ser_byte(ser_byte), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_eop(ser_eop), .tx_busy(tx_busy),
    .tx_done(tx_done),
`ifdef TX_PKT_STATS_EN
    .tx_pkt_cnt(tx_pkt_cnt), .tx_err_cnt(tx_err_cnt),
`endif
    .tx_err(tx_err)
  );

  // Upstream data_buffer model: head byte at rdptr, popped by buf_get.
  logic [7:0] mem [0:255];
  logic [7:0] rdptr = 8'd0;
  assign buf_rdata = mem[rdptr];
  always @(posedge clk) if (buf_get) rdptr <= rdptr + 8'd1;

  // Expected wire stream for the packet under test.
  logic [7:0] exp_b [0:79];
  int         exp_n = 0;
  logic [7:0] pl [$];
  logic       mon_en = 1'b0;
  int         got_base = 0;

  // Monitor counters, written only here.
  int cyc = 0, got_n = 0, nget = 0, neop = 0, ndone = 0, nerr = 0, done_cyc = 0;
  int bad_byte = 0, bad_get = 0, bad_eop = 0, bad_busy = 0;

  always @(negedge clk) begin : mon
    int idx;
    idx = got_n - got_base;
    cyc <= cyc + 1;
    if (ser_valid && ser_ready) got_n <= got_n + 1;
    if (mon_en && ser_valid && ((idx >= exp_n) || (ser_byte !== exp_b[idx])))
      bad_byte <= bad_byte + 1;
    if (buf_get) nget <= nget + 1;
    if (buf_get && !(ser_valid && ser_ready)) bad_get <= bad_get + 1;
    if (ser_eop && ser_ready) neop <= neop + 1;
    if (ser_eop && ser_valid) bad_eop <= bad_eop + 1;
    if (tx_done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
    end
    if (tx_done && !tx_busy) bad_busy <= bad_busy + 1;
    if (tx_err) nerr <= nerr + 1;
  end

  int nchk = 0, npass = 0, nfail = 0;
  int pkts_since_rst = 0, errs_since_rst = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  // CRC16 as the polynomial 0x8005 applied MSB-first to the LSB-first bit
  // stream, then bit-reversed and inverted for the wire.
  function automatic logic [15:0] crc_wire();
    logic [15:0] r;
    logic [15:0] o;
    logic        fb;
    r = 16'hFFFF;
    foreach (pl[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = r[15] ^ pl[k][i];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) o[i] = r[15-i];
    return ~o;
  endfunction

  task automatic prep(input logic [3:0] pid, input logic hd, input int occ, input logic fixed);
    int n;
    logic [7:0]  pb;
    logic [15:0] c;
    n = (occ > 64) ? 64 : occ;
    pl.delete();
    for (int i = 0; i < occ; i++) begin
      pb = fixed ? 8'(i + 1) : 8'($urandom);
      mem[8'(int'(rdptr) + i)] = pb;
      if (i < n) pl.push_back(pb);
    end
    exp_b[0] = 8'h80;
    exp_b[1] = {~pid, pid};
    exp_n = 2;
    if (hd) begin
      foreach (pl[k]) begin
        exp_b[exp_n] = pl[k];
        exp_n++;
      end
      c = crc_wire();
      exp_b[exp_n]   = c[7:0];
      exp_b[exp_n+1] = c[15:8];
      exp_n += 2;
    end
  endtask

  task automatic run_pkt(input string nm, input logic [3:0] pid, input logic hd,
                         input int occ, input int mode, input int err_at, input logic fixed);
    int   n, get0, eop0, done0, err0, bad0, start_c;
    logic fin, pulsed;
    n = (occ > 64) ? 64 : occ;
    @(posedge clk); #1;
    prep(pid, hd, occ, fixed);
    got_base = got_n;
    get0  = nget;
    eop0  = neop;
    done0 = ndone;
    err0  = nerr;
    bad0  = bad_byte + bad_get + bad_eop + bad_busy;
    mon_en      = 1'b1;
    tx_start    = 1'b1;
    tx_pid      = pid;
    tx_has_data = hd;
    buf_occ     = 7'(occ);
    ser_ready   = 1'b1;
    start_c     = cyc;
    fin    = 1'b0;
    pulsed = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      tx_start = 1'b0;
      if (mode == 0)      ser_ready = 1'b1;
      else if (mode == 1) ser_ready = t[0];
      else                ser_ready = ($urandom_range(0, 3) != 0);
      if (ndone > done0) begin
        fin = 1'b1;
        break;
      end
      if (err_at > 0 && !pulsed && (got_n - got_base) >= err_at) begin
        tx_start = 1'b1;
        pulsed   = 1'b1;
      end
    end
    tx_start  = 1'b0;
    ser_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk({nm, ".finished"}, 32'(fin), 32'd1);
    chk({nm, ".nbytes"}, 32'(got_n - got_base), 32'(exp_n));
    chk({nm, ".byte_errs"}, 32'(bad_byte + bad_get + bad_eop + bad_busy - bad0), 32'd0);
    chk({nm, ".buf_get"}, 32'(nget - get0), 32'(hd ? n : 0));
    chk({nm, ".eop"}, 32'(neop - eop0), 32'd1);
    chk({nm, ".done"}, 32'(ndone - done0), 32'd1);
    chk({nm, ".err"}, 32'(nerr - err0), 32'(pulsed ? 1 : 0));
    chk({nm, ".idle_busy"}, 32'(tx_busy), 32'd0);
    if (mode == 0) chk({nm, ".latency"}, 32'(done_cyc - start_c), 32'(4 + (hd ? n + 2 : 0)));
    if (fin) pkts_since_rst++;
    if (pulsed) errs_since_rst++;
  endtask

  initial begin
    int get0, done0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; tx_has_data = 1'b0;
    buf_occ = 7'd0; ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ser_valid", 32'(ser_valid), 32'd0);
    chk("rst.ser_byte", 32'(ser_byte), 32'd0);
    chk("rst.buf_get", 32'(buf_get), 32'd0);
    chk("rst.ser_eop", 32'(ser_eop), 32'd0);
    chk("rst.tx_busy", 32'(tx_busy), 32'd0);
    chk("rst.tx_done", 32'(tx_done), 32'd0);
    chk("rst.tx_err", 32'(tx_err), 32'd0);
    rst = 1'b0;

    run_pkt("ack",   4'h2, 1'b0, 5,  0, 0, 1'b0);
    run_pkt("zlp",   4'h3, 1'b1, 0,  0, 0, 1'b0);
    run_pkt("data1", 4'hB, 1'b1, 4,  1, 0, 1'b1);
    run_pkt("clamp", 4'h3, 1'b1, 70, 2, 0, 1'b0);
    run_pkt("err",   4'h3, 1'b1, 8,  0, 4, 1'b0);
    for (int k = 0; k < 4; k++)
      run_pkt("rand", 4'($urandom), 1'($urandom), $urandom_range(0, 70), 2, 0, 1'b0);

    // Reset in the middle of the payload.
    @(posedge clk); #1;
    prep(4'h3, 1'b1, 10, 1'b0);
    got_base = got_n;
    mon_en = 1'b1;
    tx_start = 1'b1; tx_pid = 4'h3; tx_has_data = 1'b1; buf_occ = 7'd10; ser_ready = 1'b1;
    for (int t = 0; t < 20 && (got_n - got_base) < 4; t++) begin
      @(posedge clk); #1;
      tx_start = 1'b0;
    end
    tx_start = 1'b0;
    chk("mid.in_data", 32'(got_n - got_base), 32'd4);
    rst = 1'b1;
    mon_en = 1'b0;
    get0  = nget;
    done0 = ndone;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    pkts_since_rst = 0;
    errs_since_rst = 0;
    chk("mid.ser_valid", 32'(ser_valid), 32'd0);
    chk("mid.ser_byte", 32'(ser_byte), 32'd0);
    chk("mid.buf_get", 32'(buf_get), 32'd0);
    chk("mid.ser_eop", 32'(ser_eop), 32'd0);
    chk("mid.tx_busy", 32'(tx_busy), 32'd0);
    chk("mid.tx_done", 32'(tx_done), 32'd0);
    chk("mid.tx_err", 32'(tx_err), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid.no_get", 32'(nget - get0), 32'd0);
    chk("mid.no_done", 32'(ndone - done0), 32'd0);

    run_pkt("after_rst", 4'hB, 1'b1, 6, 0, 0, 1'b0);
    run_pkt("err2",      4'hB, 1'b1, 5, 2, 3, 1'b0);

`ifdef TX_PKT_STATS_EN
    chk("stats.pkt_cnt", 32'(tx_pkt_cnt), 32'(pkts_since_rst));
    chk("stats.err_cnt", 32'(tx_err_cnt), 32'(errs_since_rst));
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
